box_cmd_rx: RTL and testbench



---
 rtl/box_cmd_pkg.sv | 33 +++
 rtl/box_rec_decode.sv | 62 ++++++
 rtl/box_cmd_rx.sv | 259 +++++++++++++++++++++++++
 tb/tb_box_cmd_rx.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/box_cmd_pkg.sv
// rtl/box_cmd_pkg.sv - shared types, widths and constants for the box command receiver
package box_cmd_pkg;

    localparam int         REC_BYTES     = 6;
    localparam int         REC_BITS      = REC_BYTES * 8;
    localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

    function automatic int calc_xw(input int h_act);
        return $clog2(h_act);
    endfunction

    function automatic int calc_yw(input int v_act);
        return $clog2(v_act);
    endfunction

    // Wire layout of one box record, MSB first.
    typedef struct packed {
        logic [10:0] x0;
        logic [9:0]  y0;
        logic [10:0] x1;
        logic [9:0]  y1;
        logic [5:0]  c;     // R2 G2 B2
    } box_rec_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_BODY,
        ST_CSUM,
        ST_DRAIN
    } rx_state_e;

endpackage

// File: rtl/box_rec_decode.sv
// rtl/box_rec_decode.sv - combinational box record decoder with optional clip/swap
// Ports:
//   rec_i    48-bit big-endian box record
//   x0_o/x1_o, y0_o/y1_o  decoded coordinates (XW / YW bits)
//   rgb_o    RGB888 colour, each 2-bit channel replicated to 8 bits
// Macro BOX_CMD_CLIP_EN: clamp x/y to the active area, then order each pair low-to-high.
module box_rec_decode
    import box_cmd_pkg::*;
#(
    parameter int H_ACT = 1280,
    parameter int V_ACT = 720,
    localparam int XW = calc_xw(H_ACT),
    localparam int YW = calc_yw(V_ACT)
) (
    input  logic [REC_BITS-1:0] rec_i,
    output logic [XW-1:0]       x0_o,
    output logic [YW-1:0]       y0_o,
    output logic [XW-1:0]       x1_o,
    output logic [YW-1:0]       y1_o,
    output logic [23:0]         rgb_o
);

    box_rec_t    r;
    logic [10:0] x0_c, x1_c;
    logic [9:0]  y0_c, y1_c;

    assign r = rec_i;

`ifdef BOX_CMD_CLIP_EN
    localparam logic [10:0] X_MAX = 11'(H_ACT - 1);
    localparam logic [9:0]  Y_MAX = 10'(V_ACT - 1);

    logic [10:0] xa, xb;
    logic [9:0]  ya, yb;

    always_comb begin
        // Clamp first so the swap compares on-screen values.
        xa   = (r.x0 > X_MAX) ? X_MAX : r.x0;
        xb   = (r.x1 > X_MAX) ? X_MAX : r.x1;
        ya   = (r.y0 > Y_MAX) ? Y_MAX : r.y0;
        yb   = (r.y1 > Y_MAX) ? Y_MAX : r.y1;
        x0_c = (xa > xb) ? xb : xa;
        x1_c = (xa > xb) ? xa : xb;
        y0_c = (ya > yb) ? yb : ya;
        y1_c = (ya > yb) ? ya : yb;
    end
`else
    always_comb begin
        x0_c = r.x0;
        x1_c = r.x1;
        y0_c = r.y0;
        y1_c = r.y1;
    end
`endif

    assign x0_o  = XW'(x0_c);
    assign x1_o  = XW'(x1_c);
    assign y0_o  = YW'(y0_c);
    assign y1_o  = YW'(y1_c);
    assign rgb_o = {{4{r.c[5:4]}}, {4{r.c[3:2]}}, {4{r.c[1:0]}}};

endmodule

// File: rtl/box_cmd_rx.sv
// rtl/box_cmd_rx.sv - checked box command packet receiver with frame-synchronous commit
// Ports:
//   clk, rst (sync, active high)
//   rx_valid/rx_data/rx_error  UDP payload byte stream, one high run per packet
//   frame_sync                 vsync level in the clk domain; rising edge commits
//   start_xs/start_ys/end_xs/end_ys/colors/box_en  live box set, slot i at [i*W +: W]
//   pending                    shadow holds an accepted, uncommitted set
//   good_cnt/bad_cnt           saturating packet counters
// Macro BOX_CMD_CLIP_EN (in box_rec_decode): clamp and order coordinates.
module box_cmd_rx
    import box_cmd_pkg::*;
#(
    parameter int         N_BOX = 1,
    parameter int         H_ACT = 1280,
    parameter int         V_ACT = 720,
    parameter logic [7:0] MAGIC = MAGIC_DEFAULT,
    localparam int XW = calc_xw(H_ACT),
    localparam int YW = calc_yw(V_ACT)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx_valid,
    input  logic [7:0]          rx_data,
    input  logic                rx_error,
    input  logic                frame_sync,
    output logic [N_BOX*XW-1:0] start_xs,
    output logic [N_BOX*YW-1:0] start_ys,
    output logic [N_BOX*XW-1:0] end_xs,
    output logic [N_BOX*YW-1:0] end_ys,
    output logic [N_BOX*24-1:0] colors,
    output logic [N_BOX-1:0]    box_en,
    output logic                pending,
    output logic [15:0]         good_cnt,
    output logic [15:0]         bad_cnt
);

    rx_state_e   state_q, state_d;
    logic [7:0]  n_q, n_d, k_q, k_d, xor_q, xor_d;
    logic [2:0]  bcnt_q, bcnt_d;
    logic [39:0] shreg_q, shreg_d;
    logic        ok_q, ok_d, bad_seen_q, bad_seen_d;
    logic        pending_q, pending_d;
    logic [15:0] good_q, good_d, bad_q, bad_d;
    logic        fs_q;
    logic        sync_rise, bad_evt;

    logic [XW-1:0]    sh_x0_q [N_BOX], sh_x0_d [N_BOX], sh_x1_q [N_BOX], sh_x1_d [N_BOX];
    logic [YW-1:0]    sh_y0_q [N_BOX], sh_y0_d [N_BOX], sh_y1_q [N_BOX], sh_y1_d [N_BOX];
    logic [23:0]      sh_rgb_q[N_BOX], sh_rgb_d[N_BOX];
    logic [N_BOX-1:0] sh_en_q, sh_en_d;
    logic [XW-1:0]    lv_x0_q [N_BOX], lv_x0_d [N_BOX], lv_x1_q [N_BOX], lv_x1_d [N_BOX];
    logic [YW-1:0]    lv_y0_q [N_BOX], lv_y0_d [N_BOX], lv_y1_q [N_BOX], lv_y1_d [N_BOX];
    logic [23:0]      lv_rgb_q[N_BOX], lv_rgb_d[N_BOX];
    logic [N_BOX-1:0] lv_en_q, lv_en_d;

    logic [XW-1:0] dec_x0, dec_x1;
    logic [YW-1:0] dec_y0, dec_y1;
    logic [23:0]   dec_rgb;

    // The record completes on the byte currently on rx_data.
    box_rec_decode #(.H_ACT(H_ACT), .V_ACT(V_ACT)) u_dec (
        .rec_i ({shreg_q, rx_data}),
        .x0_o  (dec_x0),
        .y0_o  (dec_y0),
        .x1_o  (dec_x1),
        .y1_o  (dec_y1),
        .rgb_o (dec_rgb)
    );

    assign sync_rise = frame_sync & ~fs_q;

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        k_d        = k_q;
        xor_d      = xor_q;
        bcnt_d     = bcnt_q;
        shreg_d    = shreg_q;
        ok_d       = ok_q;
        bad_seen_d = bad_seen_q;
        pending_d  = pending_q;
        good_d     = good_q;
        bad_d      = bad_q;
        bad_evt    = 1'b0;
        sh_x0_d = sh_x0_q; sh_y0_d = sh_y0_q; sh_x1_d = sh_x1_q; sh_y1_d = sh_y1_q;
        sh_rgb_d = sh_rgb_q; sh_en_d = sh_en_q;
        lv_x0_d = lv_x0_q; lv_y0_d = lv_y0_q; lv_x1_d = lv_x1_q; lv_y1_d = lv_y1_q;
        lv_rgb_d = lv_rgb_q; lv_en_d = lv_en_q;

        // Commit uses the registered pending, so an acceptance in this same
        // cycle waits for the next sync edge.
        if (sync_rise && pending_q) begin
            lv_x0_d = sh_x0_q; lv_y0_d = sh_y0_q; lv_x1_d = sh_x1_q; lv_y1_d = sh_y1_q;
            lv_rgb_d = sh_rgb_q; lv_en_d = sh_en_q;
            pending_d = 1'b0;
        end

        if (state_q == ST_IDLE) begin
            if (rx_valid) begin
                pending_d  = 1'b0;
                bad_seen_d = 1'b0;
                ok_d       = 1'b0;
                xor_d      = rx_data;
                if (rx_data == MAGIC) begin
                    state_d = ST_COUNT;
                end else begin
                    bad_evt = 1'b1;
                    state_d = ST_DRAIN;
                end
            end
        end else if (rx_error) begin
            bad_evt = 1'b1;
            ok_d    = 1'b0;
            state_d = ST_DRAIN;
        end else begin
            case (state_q)
                ST_COUNT: begin
                    if (!rx_valid) begin
                        bad_evt = 1'b1;
                        state_d = ST_IDLE;
                    end else if (rx_data == 8'd0 || rx_data > 8'(N_BOX)) begin
                        bad_evt = 1'b1;
                        state_d = ST_DRAIN;
                    end else begin
                        n_d     = rx_data;
                        k_d     = 8'd0;
                        bcnt_d  = 3'd0;
                        sh_en_d = '0;
                        xor_d   = xor_q ^ rx_data;
                        state_d = ST_BODY;
                    end
                end
                ST_BODY: begin
                    if (!rx_valid) begin
                        bad_evt = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        xor_d   = xor_q ^ rx_data;
                        shreg_d = {shreg_q[31:0], rx_data};
                        if (bcnt_q == 3'(REC_BYTES - 1)) begin
                            bcnt_d = 3'd0;
                            for (int i = 0; i < N_BOX; i++) begin
                                if (k_q == 8'(i)) begin
                                    sh_x0_d[i]  = dec_x0;
                                    sh_y0_d[i]  = dec_y0;
                                    sh_x1_d[i]  = dec_x1;
                                    sh_y1_d[i]  = dec_y1;
                                    sh_rgb_d[i] = dec_rgb;
                                    sh_en_d[i]  = 1'b1;
                                end
                            end
                            k_d = k_q + 8'd1;
                            if (k_q + 8'd1 == n_q) begin
                                state_d = ST_CSUM;
                            end
                        end else begin
                            bcnt_d = bcnt_q + 3'd1;
                        end
                    end
                end
                ST_CSUM: begin
                    if (!rx_valid) begin
                        bad_evt = 1'b1;
                        state_d = ST_IDLE;
                    end else if (rx_data == xor_q) begin
                        ok_d    = 1'b1;
                        state_d = ST_DRAIN;
                    end else begin
                        bad_evt = 1'b1;
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!rx_valid) begin
                        if (ok_q) begin
                            pending_d = 1'b1;
                            if (good_q != 16'hFFFF) begin
                                good_d = good_q + 16'd1;
                            end
                        end
                        ok_d    = 1'b0;
                        state_d = ST_IDLE;
                    end else if (ok_q) begin
                        // Trailing byte after a good checksum spoils the packet.
                        bad_evt = 1'b1;
                        ok_d    = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // bad_seen_q is stale in IDLE; a new run always gets one count.
        if (bad_evt) begin
            bad_seen_d = 1'b1;
            if ((state_q == ST_IDLE || !bad_seen_q) && bad_q != 16'hFFFF) begin
                bad_d = bad_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            n_q        <= 8'd0;
            k_q        <= 8'd0;
            xor_q      <= 8'd0;
            bcnt_q     <= 3'd0;
            shreg_q    <= 40'd0;
            ok_q       <= 1'b0;
            bad_seen_q <= 1'b0;
            pending_q  <= 1'b0;
            good_q     <= 16'd0;
            bad_q      <= 16'd0;
            fs_q       <= 1'b0;
            sh_en_q    <= '0;
            lv_en_q    <= '0;
            for (int i = 0; i < N_BOX; i++) begin
                sh_x0_q[i] <= '0; sh_y0_q[i] <= '0; sh_x1_q[i] <= '0; sh_y1_q[i] <= '0;
                sh_rgb_q[i] <= '0;
                lv_x0_q[i] <= '0; lv_y0_q[i] <= '0; lv_x1_q[i] <= '0; lv_y1_q[i] <= '0;
                lv_rgb_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            k_q        <= k_d;
            xor_q      <= xor_d;
            bcnt_q     <= bcnt_d;
            shreg_q    <= shreg_d;
            ok_q       <= ok_d;
            bad_seen_q <= bad_seen_d;
            pending_q  <= pending_d;
            good_q     <= good_d;
            bad_q      <= bad_d;
            fs_q       <= frame_sync;
            sh_en_q    <= sh_en_d;
            lv_en_q    <= lv_en_d;
            sh_x0_q <= sh_x0_d; sh_y0_q <= sh_y0_d; sh_x1_q <= sh_x1_d; sh_y1_q <= sh_y1_d;
            sh_rgb_q <= sh_rgb_d;
            lv_x0_q <= lv_x0_d; lv_y0_q <= lv_y0_d; lv_x1_q <= lv_x1_d; lv_y1_q <= lv_y1_d;
            lv_rgb_q <= lv_rgb_d;
        end
    end

    for (genvar i = 0; i < N_BOX; i++) begin : g_out
        assign start_xs[i*XW +: XW] = lv_x0_q[i];
        assign start_ys[i*YW +: YW] = lv_y0_q[i];
        assign end_xs[i*XW +: XW]   = lv_x1_q[i];
        assign end_ys[i*YW +: YW]   = lv_y1_q[i];
        assign colors[i*24 +: 24]   = lv_rgb_q[i];
    end

    assign box_en   = lv_en_q;
    assign pending  = pending_q;
    assign good_cnt = good_q;
    assign bad_cnt  = bad_q;

endmodule

// File: tb/tb_box_cmd_rx.sv
// tb/tb_box_cmd_rx.sv - directed self-checking bench for box_cmd_rx
module tb_box_cmd_rx;

    localparam int N_BOX = 2;
    localparam int XW    = 11;
    localparam int YW    = 10;

    logic clk = 1'b0;
    logic rst, rx_valid, rx_error, frame_sync;
    logic [7:0] rx_data;
    logic [N_BOX*XW-1:0] start_xs, end_xs;
    logic [N_BOX*YW-1:0] start_ys, end_ys;
    logic [N_BOX*24-1:0] colors;
    logic [N_BOX-1:0]    box_en;
    logic                pending;
    logic [15:0]         good_cnt, bad_cnt;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] pkt[$];

    box_cmd_rx #(.N_BOX(N_BOX), .H_ACT(1280), .V_ACT(720), .MAGIC(8'hA5)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_error(rx_error),
        .frame_sync(frame_sync), .start_xs(start_xs), .start_ys(start_ys), .end_xs(end_xs),
        .end_ys(end_ys), .colors(colors), .box_en(box_en), .pending(pending),
        .good_cnt(good_cnt), .bad_cnt(bad_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_slot(input string tag, input int s, input int x0, input int y0,
                              input int x1, input int y1, input logic [23:0] rgb);
        check({tag, ".x0"}, 64'(start_xs[s*XW +: XW]), 64'(x0));
        check({tag, ".y0"}, 64'(start_ys[s*YW +: YW]), 64'(y0));
        check({tag, ".x1"}, 64'(end_xs[s*XW +: XW]), 64'(x1));
        check({tag, ".y1"}, 64'(end_ys[s*YW +: YW]), 64'(y1));
        check({tag, ".rgb"}, 64'(colors[s*24 +: 24]), 64'(rgb));
    endtask

    task automatic check_stat(input string tag, input int good, input int bad, input logic pend);
        check({tag, ".good"}, 64'(good_cnt), 64'(good));
        check({tag, ".bad"}, 64'(bad_cnt), 64'(bad));
        check({tag, ".pend"}, 64'(pending), 64'(pend));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".sx"}, 64'(start_xs), 64'd0);
        check({tag, ".sy"}, 64'(start_ys), 64'd0);
        check({tag, ".ex"}, 64'(end_xs), 64'd0);
        check({tag, ".ey"}, 64'(end_ys), 64'd0);
        check({tag, ".col"}, 64'(colors), 64'd0);
        check({tag, ".en"}, 64'(box_en), 64'd0);
        check_stat(tag, 0, 0, 1'b0);
    endtask

    task automatic pkt_head(input logic [7:0] magic, input logic [7:0] n);
        pkt.delete();
        pkt.push_back(magic);
        pkt.push_back(n);
    endtask

    task automatic pkt_rec(input logic [10:0] x0, input logic [9:0] y0, input logic [10:0] x1,
                           input logic [9:0] y1, input logic [5:0] c);
        logic [47:0] r;
        r = {x0, y0, x1, y1, c};
        for (int i = 5; i >= 0; i--) pkt.push_back(r[i*8 +: 8]);
    endtask

    task automatic pkt_csum(input logic [7:0] flip);
        logic [7:0] x;
        x = 8'd0;
        foreach (pkt[i]) x ^= pkt[i];
        pkt.push_back(x ^ flip);
    endtask

    // Leaves the bench at the negedge one cycle after the first low cycle.
    task automatic send_pkt(input int err_idx, input bit sync_at_end);
        for (int i = 0; i < pkt.size(); i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = pkt[i];
            rx_error = (i == err_idx);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        rx_error = 1'b0;
        rx_data  = 8'd0;
        if (sync_at_end) frame_sync = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_sync();
        @(negedge clk);
        frame_sync = 1'b1;
        @(negedge clk);
        frame_sync = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_error = 1'b0; rx_data = 8'd0; frame_sync = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Good packet, then commit.
        pkt_head(8'hA5, 8'd1); pkt_rec(32, 16, 64, 48, 6'b110000); pkt_csum(8'h00);
        send_pkt(-1, 1'b0);
        check_stat("goodA", 1, 0, 1'b1);
        check("goodA.pre_en", 64'(box_en), 64'd0);
        check("goodA.pre_sx", 64'(start_xs), 64'd0);
        pulse_sync();
        check_slot("goodA.s0", 0, 32, 16, 64, 48, 24'hFF0000);
        check("goodA.en", 64'(box_en), 64'b01);
        check_stat("goodA.post", 1, 0, 1'b0);

        // Corrupted checksum: rejected, live set survives the edge.
        pkt_head(8'hA5, 8'd1); pkt_rec(1, 2, 3, 4, 6'b000011); pkt_csum(8'h01);
        send_pkt(-1, 1'b0);
        check_stat("badcs", 1, 1, 1'b0);
        pulse_sync();
        check_slot("badcs.s0", 0, 32, 16, 64, 48, 24'hFF0000);
        check("badcs.en", 64'(box_en), 64'b01);

        // Count byte out of range on both sides.
        pkt_head(8'hA5, 8'd0); pkt_csum(8'h00);
        send_pkt(-1, 1'b0);
        check_stat("cnt0", 1, 2, 1'b0);
        pkt_head(8'hA5, 8'd3); pkt_csum(8'h00);
        send_pkt(-1, 1'b0);
        check_stat("cnt3", 1, 3, 1'b0);

        // Run ends after 4 record bytes.
        pkt_head(8'hA5, 8'd1); pkt_rec(32, 16, 64, 48, 6'b110000);
        repeat (2) void'(pkt.pop_back());
        send_pkt(-1, 1'b0);
        check_stat("short", 1, 4, 1'b0);

        // Wrong magic.
        pkt_head(8'h5A, 8'd1); pkt_rec(32, 16, 64, 48, 6'b110000); pkt_csum(8'h00);
        send_pkt(-1, 1'b0);
        check_stat("magic", 1, 5, 1'b0);

        // rx_error mid-body: one bad count for the whole run.
        pkt_head(8'hA5, 8'd1); pkt_rec(32, 16, 64, 48, 6'b110000); pkt_csum(8'h00);
        send_pkt(3, 1'b0);
        check_stat("rxerr", 1, 6, 1'b0);

        // Extra byte after a good checksum.
        pkt_head(8'hA5, 8'd1); pkt_rec(32, 16, 64, 48, 6'b110000); pkt_csum(8'h00);
        pkt.push_back(8'h00);
        send_pkt(-1, 1'b0);
        check_stat("extra", 1, 7, 1'b0);

        // Two-slot packet.
        pkt_head(8'hA5, 8'd2);
        pkt_rec(100, 50, 200, 150, 6'b001100); pkt_rec(300, 400, 1279, 719, 6'b111111);
        pkt_csum(8'h00);
        send_pkt(-1, 1'b0);
        check_stat("p1", 2, 7, 1'b1);
        pulse_sync();
        check_slot("p1.s0", 0, 100, 50, 200, 150, 24'h00FF00);
        check_slot("p1.s1", 1, 300, 400, 1279, 719, 24'hFFFFFF);
        check("p1.en", 64'(box_en), 64'b11);

        // Two good packets before one edge: the later one wins.
        pkt_head(8'hA5, 8'd2);
        pkt_rec(5, 6, 7, 8, 6'b010101); pkt_rec(9, 10, 11, 12, 6'b101010);
        pkt_csum(8'h00);
        send_pkt(-1, 1'b0);
        pkt_head(8'hA5, 8'd1); pkt_rec(640, 360, 700, 400, 6'b100100); pkt_csum(8'h00);
        send_pkt(-1, 1'b0);
        check_stat("p3", 4, 7, 1'b1);
        pulse_sync();
        check_slot("p3.s0", 0, 640, 360, 700, 400, 24'hAA5500);
        check("p3.en", 64'(box_en), 64'b01);

        // Acceptance in the same cycle as the sync rise commits on the next rise.
        pkt_head(8'hA5, 8'd1); pkt_rec(10, 20, 30, 40, 6'b000001); pkt_csum(8'h00);
        send_pkt(-1, 1'b1);
        check_stat("same", 5, 7, 1'b1);
        check_slot("same.held", 0, 640, 360, 700, 400, 24'hAA5500);
        frame_sync = 1'b0;
        @(negedge clk);
        pulse_sync();
        check_slot("same.s0", 0, 10, 20, 30, 40, 24'h000055);
        check("same.pend", 64'(pending), 64'd0);

        // Out-of-range and reversed x.
        pkt_head(8'hA5, 8'd1); pkt_rec(1500, 10, 100, 20, 6'b011011); pkt_csum(8'h00);
        send_pkt(-1, 1'b0);
        pulse_sync();
`ifdef BOX_CMD_CLIP_EN
        check_slot("clip.s0", 0, 100, 10, 1279, 20, 24'h55AAFF);
`else
        check_slot("clip.s0", 0, 1500, 10, 100, 20, 24'h55AAFF);
`endif
        check_stat("clip", 6, 7, 1'b0);

        // Reset in the middle of the body.
        pkt_head(8'hA5, 8'd1); pkt_rec(32, 16, 64, 48, 6'b110000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = pkt[i];
        end
        @(negedge clk);
        rst = 1'b1;
        rx_valid = 1'b0;
        @(negedge clk);
        check_all_zero("rstmid");
        rst = 1'b0;
        @(negedge clk);
        pkt_head(8'hA5, 8'd1); pkt_rec(32, 16, 64, 48, 6'b110000); pkt_csum(8'h00);
        send_pkt(-1, 1'b0);
        check_stat("afterrst", 1, 0, 1'b1);
        pulse_sync();
        check_slot("afterrst.s0", 0, 32, 16, 64, 48, 24'hFF0000);
        check("afterrst.en", 64'(box_en), 64'b01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
